// File: rtl/uart_cmd_wbm.sv
// UART command engine: parses ASCII "wm <adr> <dat>\n" / "rm <adr>\n" commands,
// runs one 32-bit Wishbone master transfer and streams back the ASCII response.
module uart_cmd_wbm #(
   parameter int unsigned TO_CYC = 1023,
   parameter int unsigned TO_W   = 10
) (
   input  logic        app_clk,
   input  logic        arst_n,
   input  logic        rx_vld,
   input  logic [7:0]  rx_data,
   input  logic        tx_rdy,
   output logic        tx_vld,
   output logic [7:0]  tx_data,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        rx_drop
);

   typedef enum logic [2:0] {StIdle, StC2, StS1, StAdr, StDat, StDisc, StWb, StRsp} state_t;
   typedef enum logic [1:0] {RspOk, RspEr, RspRd} rsp_t;

   localparam logic [7:0] ChLf = 8'h0a;
   localparam logic [7:0] ChCr = 8'h0d;
   localparam logic [7:0] ChSp = 8'h20;
   localparam logic [7:0] ChW  = 8'h77;
   localparam logic [7:0] ChR  = 8'h72;
   localparam logic [7:0] ChM  = 8'h6d;
   localparam logic [TO_W-1:0] ToLast = TO_W'(TO_CYC - 1);

   state_t          state;
   rsp_t            rsp_kind;
   logic [3:0]      rsp_idx;
   logic [3:0]      ndig;
   logic            op_wr;
   logic [31:0]     acc_adr;
   logic [31:0]     acc_dat;
   logic [31:0]     rd_data;
   logic [TO_W-1:0] to_cnt;

   logic       hex_ok;
   logic [3:0] hex_nib;
   logic       byte_in;
   state_t     err_next;
   logic [3:0] rsp_last;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [7:0] rsp_char(input rsp_t kind, input logic [3:0] idx,
                                           input logic [31:0] d);
      logic [31:0] s;
      s = d << {idx, 2'b00};
      unique case (kind)
         RspRd:   return (idx == 4'd8) ? ChLf : hex_char(s[31:28]);
         RspOk:   return (idx == 4'd0) ? 8'h6f : (idx == 4'd1) ? 8'h6b : ChLf;
         default: return (idx == 4'd0) ? 8'h65 : (idx == 4'd1) ? 8'h72 : ChLf;
      endcase
   endfunction

   // Decode the incoming byte as a case-insensitive hex digit.
   always_comb begin
      hex_ok  = 1'b1;
      hex_nib = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39)      hex_nib = 4'(rx_data - 8'h30);
      else if (rx_data >= 8'h61 && rx_data <= 8'h66) hex_nib = 4'(rx_data - 8'h57);
      else if (rx_data >= 8'h41 && rx_data <= 8'h46) hex_nib = 4'(rx_data - 8'h37);
      else                                           hex_ok  = 1'b0;
   end

   // CR is invisible to the parser; a malformed LF jumps straight to the error reply.
   assign byte_in  = rx_vld && (rx_data != ChCr);
   assign err_next = (rx_data == ChLf) ? StRsp : StDisc;
   assign rsp_last = (rsp_kind == RspRd) ? 4'd8 : 4'd2;

   assign wbm_adr_o = acc_adr;
   assign wbm_dat_o = acc_dat;

   // Parser, Wishbone master and response sequencer in one registered FSM.
   always_ff @(posedge app_clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= StIdle;
         rsp_kind  <= RspEr;
         rsp_idx   <= 4'd0;
         ndig      <= 4'd0;
         op_wr     <= 1'b0;
         acc_adr   <= 32'h0;
         acc_dat   <= 32'h0;
         rd_data   <= 32'h0;
         to_cnt    <= '0;
         tx_vld    <= 1'b0;
         tx_data   <= 8'h0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'h0;
         rx_drop   <= 1'b0;
      end else begin
         rx_drop <= rx_vld && (state == StWb || state == StRsp);
         case (state)
            StIdle: begin
               rsp_idx  <= 4'd0;
               rsp_kind <= RspEr;
               if (byte_in) begin
                  if (rx_data == ChW || rx_data == ChR) begin
                     op_wr <= (rx_data == ChW);
                     state <= StC2;
                  end else if (rx_data != ChLf) begin
                     state <= StDisc;
                  end
               end
            end
            StC2: if (byte_in) state <= (rx_data == ChM) ? StS1 : err_next;
            StS1: begin
               if (byte_in) begin
                  if (rx_data == ChSp) begin
                     state   <= StAdr;
                     acc_adr <= 32'h0;
                     ndig    <= 4'd0;
                  end else begin
                     state <= err_next;
                  end
               end
            end
            StAdr: begin
               if (byte_in) begin
                  if (hex_ok) begin
                     if (ndig == 4'd8) state <= StDisc;
                     else begin
                        acc_adr <= {acc_adr[27:0], hex_nib};
                        ndig    <= ndig + 4'd1;
                     end
                  end else if (rx_data == ChSp && ndig != 4'd0 && op_wr) begin
                     state   <= StDat;
                     acc_dat <= 32'h0;
                     ndig    <= 4'd0;
                  end else if (rx_data == ChLf && ndig != 4'd0 && !op_wr) begin
                     state     <= StWb;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b0;
                     wbm_sel_o <= 4'hf;
                     to_cnt    <= '0;
                  end else begin
                     state <= err_next;
                  end
               end
            end
            StDat: begin
               if (byte_in) begin
                  if (hex_ok) begin
                     if (ndig == 4'd8) state <= StDisc;
                     else begin
                        acc_dat <= {acc_dat[27:0], hex_nib};
                        ndig    <= ndig + 4'd1;
                     end
                  end else if (rx_data == ChLf && ndig != 4'd0) begin
                     state     <= StWb;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b1;
                     wbm_sel_o <= 4'hf;
                     to_cnt    <= '0;
                  end else begin
                     state <= err_next;
                  end
               end
            end
            StDisc: if (rx_vld && rx_data == ChLf) state <= StRsp;
            StWb: begin
               // err beats ack when both arrive together
               if (wbm_err_i || wbm_ack_i || to_cnt == ToLast) begin
                  state     <= StRsp;
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= 4'h0;
                  to_cnt    <= '0;
                  if (wbm_err_i || !wbm_ack_i) begin
                     rsp_kind <= RspEr;
                  end else begin
                     rsp_kind <= op_wr ? RspOk : RspRd;
                     if (!op_wr) rd_data <= wbm_dat_i;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            StRsp: begin
               if (!tx_vld) begin
                  tx_vld  <= 1'b1;
                  tx_data <= rsp_char(rsp_kind, rsp_idx, rd_data);
               end else if (tx_rdy) begin
                  if (rsp_idx == rsp_last) begin
                     tx_vld <= 1'b0;
                     state  <= StIdle;
                  end else begin
                     rsp_idx <= rsp_idx + 4'd1;
                     tx_data <= rsp_char(rsp_kind, rsp_idx + 4'd1, rd_data);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_wbm.sv
// Directed bench for uart_cmd_wbm: command bytes in, Wishbone slave model, response capture.
module tb_uart_cmd_wbm;

   logic        app_clk = 1'b0;
   logic        arst_n;
   logic        rx_vld;
   logic [7:0]  rx_data;
   logic        tx_rdy;
   logic        tx_vld;
   logic [7:0]  tx_data;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i, wbm_err_i;
   logic        rx_drop;

   uart_cmd_wbm #(.TO_CYC(16), .TO_W(5)) dut (
      .app_clk   (app_clk),
      .arst_n    (arst_n),
      .rx_vld    (rx_vld),
      .rx_data   (rx_data),
      .tx_rdy    (tx_rdy),
      .tx_vld    (tx_vld),
      .tx_data   (tx_data),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i),
      .rx_drop   (rx_drop)
   );

   always #5 app_clk = ~app_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Slave model knobs: ack/err on the given stb cycle (0 = first), -1 = never.
   int          ack_at = 0;
   int          err_at = -1;
   logic [31:0] rdata  = 32'h0;
   int          rdy_mode = 0;   // 0: always ready, 1: one cycle in four, 2: never

   int          stb_cnt = 0;
   int          last_len = 0;
   int          n_txn = 0;
   int          n_drop = 0;
   int          stab_viol = 0;
   logic        prev_stb = 1'b0;
   logic [31:0] lat_adr = 32'h0, lat_dat = 32'h0;
   logic        lat_we = 1'b0;
   logic [3:0]  lat_sel = 4'h0;
   logic [1:0]  cyc_ctr = 2'd0;
   logic        p_vld = 1'b0, p_rdy = 1'b0;
   logic [7:0]  p_data = 8'h0;
   logic [7:0]  txq[$];

   assign wbm_ack_i = wbm_stb_o && (stb_cnt == ack_at);
   assign wbm_err_i = wbm_stb_o && (stb_cnt == err_at);
   assign wbm_dat_i = rdata;
   assign tx_rdy    = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc_ctr == 2'd0) : 1'b0;

   // Bus and UART-side monitors.
   always @(posedge app_clk) begin
      cyc_ctr  <= cyc_ctr + 2'd1;
      prev_stb <= wbm_stb_o;
      if (wbm_stb_o) stb_cnt <= stb_cnt + 1;
      else if (stb_cnt != 0) begin
         last_len <= stb_cnt;
         stb_cnt  <= 0;
      end
      if (wbm_stb_o && !prev_stb) begin
         n_txn   <= n_txn + 1;
         lat_adr <= wbm_adr_o;
         lat_dat <= wbm_dat_o;
         lat_we  <= wbm_we_o;
         lat_sel <= wbm_sel_o;
      end
      if (rx_drop) n_drop <= n_drop + 1;
      if (tx_vld && tx_rdy && arst_n) txq.push_back(tx_data);
      if (arst_n && p_vld && !p_rdy && !(tx_vld && tx_data == p_data)) stab_viol <= stab_viol + 1;
      p_vld  <= tx_vld;
      p_rdy  <= tx_rdy;
      p_data <= tx_data;
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge app_clk);
      rx_vld  = 1'b1;
      rx_data = b;
      @(negedge app_clk);
      rx_vld  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   // Wait (bounded) for n response bytes and compare them as one packed string.
   task automatic expect_rsp(input string tag, input int n, input logic [95:0] exp);
      logic [95:0] r;
      int          k;
      k = 0;
      while (txq.size() < n && k < 500) begin
         @(negedge app_clk);
         k++;
      end
      repeat (3) @(negedge app_clk);
      check({tag, "_len"}, 96'(txq.size()), 96'(n));
      r = '0;
      for (int i = 0; i < n; i++) if (txq.size() > 0) r = {r[87:0], txq.pop_front()};
      txq.delete();
      check(tag, r, exp);
   endtask

   task automatic wait_high(input string tag, input int which);
      int k;
      k = 0;
      while (k < 200 && !((which == 0) ? wbm_stb_o : tx_vld)) begin
         @(negedge app_clk);
         k++;
      end
      if (k >= 200) check({tag, "_timeout"}, 96'(0), 96'(1));
   endtask

   task automatic pulse_reset(input string tag);
      #2 arst_n = 1'b0;
      #1 check(tag, 96'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, tx_vld}), 96'(0));
      repeat (2) @(negedge app_clk);
      arst_n = 1'b1;
      txq.delete();
      repeat (2) @(negedge app_clk);
   endtask

   initial begin
      arst_n  = 1'b0;
      rx_vld  = 1'b0;
      rx_data = 8'h0;
      repeat (3) @(negedge app_clk);
      arst_n = 1'b1;
      @(negedge app_clk);
      check("rst_ctl", 96'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, tx_vld, rx_drop}), 96'(0));
      check("rst_bus", 96'({wbm_adr_o, wbm_dat_o, tx_data}), 96'(0));

      // Write, acked on the 4th stb cycle.
      ack_at = 3;
      send_str("wm 30020018 11223344\n");
      expect_rsp("wr_rsp", 3, 96'("ok\n"));
      check("wr_ntxn", 96'(n_txn), 96'(1));
      check("wr_adr", 96'(lat_adr), 96'(32'h30020018));
      check("wr_dat", 96'(lat_dat), 96'(32'h11223344));
      check("wr_we_sel", 96'({lat_we, lat_sel}), 96'(5'h1f));
      check("wr_len", 96'(last_len), 96'(4));

      // Read with CR before LF.
      ack_at = 2;
      rdata  = 32'ha5b6c7d8;
      send_str("rm 30020018\r\n");
      expect_rsp("rd_rsp", 9, 96'("a5b6c7d8\n"));
      check("rd_ntxn", 96'(n_txn), 96'(2));
      check("rd_we", 96'(lat_we), 96'(0));
      check("rd_adr", 96'(lat_adr), 96'(32'h30020018));

      // Read response under a throttled transmitter.
      rdy_mode = 1;
      rdata    = 32'h0123abcd;
      send_str("rm 1F\n");
      expect_rsp("slow_rsp", 9, 96'("0123abcd\n"));
      check("slow_adr", 96'(lat_adr), 96'(32'h1f));
      check("slow_stable", 96'(stab_viol), 96'(0));
      rdy_mode = 0;

      // Malformed commands never reach the bus.
      send_str("xm 1\n");
      expect_rsp("bad_op", 3, 96'("er\n"));
      send_str("wm 123456789 1\n");
      expect_rsp("bad_9dig", 3, 96'("er\n"));
      send_str("rm 10 2\n");
      expect_rsp("bad_rdsp", 3, 96'("er\n"));
      send_str("rm\n");
      expect_rsp("bad_lf", 3, 96'("er\n"));
      check("bad_ntxn", 96'(n_txn), 96'(3));
      send_str("wm 0 5\n");
      expect_rsp("good_rsp", 3, 96'("ok\n"));
      check("good_adr_dat", 96'({lat_adr, lat_dat}), 96'(64'h5));
      check("good_ntxn", 96'(n_txn), 96'(4));

      // Timeout, err, and err+ack together.
      ack_at = -1;
      send_str("wm 8 9\n");
      expect_rsp("to_rsp", 3, 96'("er\n"));
      check("to_len", 96'(last_len), 96'(16));
      err_at = 1;
      send_str("rm 8\n");
      expect_rsp("err_rsp", 3, 96'("er\n"));
      check("err_len", 96'(last_len), 96'(2));
      ack_at = 1;
      send_str("rm 8\n");
      expect_rsp("ackerr_rsp", 3, 96'("er\n"));
      err_at = -1;

      // Byte arriving during the response is dropped.
      ack_at   = 0;
      rdy_mode = 1;
      rdata    = 32'hdeadbeef;
      send_str("rm 4\n");
      wait_high("drop", 1);
      send_byte(8'h78);
      expect_rsp("drop_rsp", 9, 96'("deadbeef\n"));
      check("drop_cnt", 96'(n_drop), 96'(1));
      rdy_mode = 0;

      // Asynchronous reset mid-WB and mid-RSP.
      ack_at = -1;
      send_str("rm 4\n");
      wait_high("rstwb", 0);
      repeat (3) @(negedge app_clk);
      pulse_reset("rst_mid_wb");
      ack_at   = 0;
      rdy_mode = 2;
      send_str("rm 4\n");
      wait_high("rstrsp", 1);
      pulse_reset("rst_mid_rsp");
      rdy_mode = 0;
      ack_at   = 1;
      rdata    = 32'h00000004;
      send_str("rm 4\n");
      expect_rsp("post_rst_rsp", 9, 96'("00000004\n"));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_wbm.md
Name: uart_cmd_wbm

Overview:
- Device-side command engine of the UART register-access path.
- Consumes ASCII command bytes from the UART receiver and executes single 32-bit Wishbone master transactions.
- Streams the ASCII response bytes to the UART transmitter.
- Sits between the UART core and the wb_host interconnect; it is the responder to the bench's uartm_reg_write / uartm_reg_read_check traffic.

Parameters:
- TO_CYC, 1023: Wishbone ack timeout in app_clk cycles, counted from the first cycle stb is asserted.
- TO_W, 10: timeout counter width; must satisfy TO_CYC < 2**TO_W.

Ports:
- app_clk  in  1  single clock for all logic.
- arst_n  in  1  asynchronous active-low reset.
- rx_vld  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_rdy  in  1  transmitter can accept a byte.
- tx_vld  out  1  tx_data valid; held until tx_rdy is seen.
- tx_data  out  8  response byte.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  1 = write.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  always 4'hF while stb is high.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  transfer acknowledge.
- wbm_err_i  in  1  transfer error.
- rx_drop  out  1  one-cycle pulse when rx_vld arrives while busy (byte discarded).

Behaviour:
- Reset: all outputs 0, state IDLE, addr/data accumulators 0, timeout counter 0. An asserted arst_n mid-transaction drops cyc/stb immediately; no response is sent.
- Grammar: "wm" SP addr SP data LF, or "rm" SP addr LF.
  - SP is exactly one 0x20. LF is 0x0A. CR (0x0D) is ignored in every parse state.
  - addr and data are 1-8 hex digits, case-insensitive. Each digit does acc = {acc[27:0], nibble]; the accumulator is cleared on entry to the field.
- FSM states:
  - IDLE: 'w' or 'r' -> C2 with the op latched; LF -> IDLE silently; any other byte -> DISC.
  - C2: 'm' -> S1; else DISC.
  - S1: SP -> ADR; else DISC.
  - ADR: hex -> accumulate.
    - A 9th digit, or a non-hex byte, -> DISC.
    - SP with >=1 digit on a write -> DAT.
    - LF with >=1 digit on a read -> WB.
    - SP on a read, or LF on a write, -> DISC.
  - DAT: hex -> accumulate (9th digit -> DISC). LF with >=1 digit -> WB. Any other byte -> DISC.
  - DISC: wait for LF, then RSP with "er\n". LF received in the same byte as the error (e.g. "rm\n") goes directly to RSP "er\n".
  - WB: assert cyc=stb=1, we, adr, dat, sel=F on the cycle after the terminating LF, and hold them until an ack, an err, or a timeout.
    - ack -> deassert cyc/stb in the next cycle. A read captures wbm_dat_i on the ack cycle.
    - err, or counter reaching TO_CYC -> deassert; response "er\n".
    - ack and err in the same cycle: err wins.
  - RSP: emit bytes in order, one per tx_vld&tx_rdy handshake.
    - Write ok: "ok\n".
    - Read ok: 8 lowercase hex digits, MSB nibble first, then "\n".
    - tx_vld rises the cycle after entering RSP. tx_data is stable while tx_vld=1 and tx_rdy=0.
    - After the LF byte handshakes -> IDLE.
- rx_vld in WB or RSP: byte discarded and rx_drop pulses; state is unaffected.
- An rx_vld on the same cycle as the RSP->IDLE transition is dropped.
- Throughput: at most one outstanding Wishbone transaction; no pipelining.

Test Plan:
- "wm 30020018 11223344\n" with ack after 3 cycles -> one write, adr=30020018, dat=11223344, sel=F, we=1, cyc high 4 cycles; tx "ok\n".
- "rm 30020018\r\n", slave returns 0xA5B6C7D8 -> one read; tx "a5b6c7d8\n"; CR ignored.
- tx_rdy toggled 1-in-4 during a read response -> all 9 bytes are correct and in order; tx_data never changes while tx_vld=1 and tx_rdy=0.
- Malformed inputs "xm 1\n", "wm 123456789 1\n", "rm 10 2\n" -> no cyc asserted; each yields "er\n"; the next valid command succeeds.
- Slave never acks (TO_CYC=16) -> stb held exactly 16 cycles, then drops; tx "er\n". wbm_err_i on the 2nd cycle -> "er\n".
- arst_n asserted mid-WB and again mid-RSP -> outputs return to 0 asynchronously; after release, "rm 4\n" completes normally. A byte sent during RSP -> rx_drop pulse, response uncorrupted.
